// File: rtl/sid_cmd_tx.sv
// UART command transmitter for the SID board link: queues {addr, data} register
// writes and serializes each as two 8N1 frames (address byte, then data byte).
module sid_cmd_tx #(
  parameter int unsigned CLK_FREQ   = 12_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DIVIDER    = CLK_FREQ / BAUD,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK_IN,
  input  logic       RST_IN,
  input  logic       CMD_VALID_i,
  output logic       CMD_READY_o,
  input  logic [4:0] CMD_ADDR_i,
  input  logic [7:0] CMD_DATA_i,
  output logic       RS232_TX_o,
  output logic       BUSY_o
);

  localparam int unsigned CW = $clog2(DIVIDER);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDER - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [12:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   fcount_q, fcount_d;
  logic          full, empty, push, pop;
  logic [12:0]   head;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d, nxt_bit;
  logic          sel_q, sel_d;
  logic [4:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    cur_byte;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          bit_end;

  assign full        = (fcount_q == FIFO_FULL);
  assign empty       = (fcount_q == '0);
  assign push        = CMD_VALID_i && !full;
  assign head        = mem_q[rd_q];
  assign cur_byte    = sel_q ? data_q : {3'b000, addr_q};
  assign bit_end     = (baud_q == CNT_LAST);
  assign nxt_bit     = bit_q + 3'd1;
  assign CMD_READY_o = !full;
  assign RS232_TX_o  = tx_q;
  assign BUSY_o      = busy_q;

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          addr_d  = head[12:8];
          data_d  = head[7:0];
          sel_d   = 1'b0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = 3'd0;
        tx_d    = cur_byte[0];
      end
      S_DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d = nxt_bit;
          tx_d  = cur_byte[nxt_bit];
        end
      end
      default: if (bit_end) begin
        // A queued command chains straight into its start bit with no idle cycle.
        if (!sel_q) begin
          sel_d   = 1'b1;
          tx_d    = 1'b0;
          state_d = S_START;
        end else if (!empty) begin
          pop     = 1'b1;
          addr_d  = head[12:8];
          data_d  = head[7:0];
          sel_d   = 1'b0;
          tx_d    = 1'b0;
          state_d = S_START;
        end else begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase

    fcount_d = fcount_q;
    if (push && !pop)      fcount_d = fcount_q + (AW + 1)'(1);
    else if (!push && pop) fcount_d = fcount_q - (AW + 1)'(1);
    busy_d = (fcount_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge CLK_IN) begin
    if (push && !RST_IN) mem_q[wr_q] <= {CMD_ADDR_i, CMD_DATA_i};
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      wr_q     <= '0;
      rd_q     <= '0;
      fcount_q <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      fcount_q <= fcount_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

endmodule
